// File: rtl/serial_adder.sv
// serial_adder
//   Bit-serial unsigned adder. An accepted start loads both operands into
//   shift registers; one bit pair is summed per clock through a full adder
//   (two half adders plus an OR gate). After WIDTH clocks the result is
//   copied to sum/cout and done pulses for one cycle.
//
//   Parameter
//     WIDTH  operand/result width in bits (2..32), default 8
//   Ports
//     clk    clock, rising edge
//     rst_n  asynchronous active-low reset
//     start  begin an addition (accepted in IDLE or DONE, ignored in RUN)
//     a, b   operands, sampled on the accepting edge only
//     busy   high while the addition is in progress
//     done   one-cycle pulse, new result valid
//     sum    registered result of the last completed addition
//     cout   registered carry-out of the last completed addition
//     cin    carry-in, sampled on the accepting edge
//            (present only when SERIAL_ADDER_CIN_EN is defined)
//
//   Compile-time option: SERIAL_ADDER_CIN_EN enables the cin port.
module serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADDER_CIN_EN
  ,
  input  logic             cin
`endif
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic             carry;
  logic [CNT_W-1:0] cnt;
  logic             carry_init;

`ifdef SERIAL_ADDER_CIN_EN
  assign carry_init = cin;
`else
  assign carry_init = 1'b0;
`endif

  // Full adder on the operand LSBs and the carry flip-flop.
  logic ha1_s, ha1_c, ha2_c, fa_s, fa_c;

  always_comb begin
    ha1_s = a_sr[0] ^ b_sr[0];
    ha1_c = a_sr[0] & b_sr[0];
    fa_s  = ha1_s ^ carry;
    ha2_c = ha1_s & carry;
    fa_c  = ha1_c | ha2_c;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      sum    <= '0;
      cout   <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            state <= RUN;
            busy  <= 1'b1;
            a_sr  <= a;
            b_sr  <= b;
            carry <= carry_init;
            cnt   <= CNT_W'(WIDTH);
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end

        RUN: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          res_sr <= {fa_s, res_sr[WIDTH-1:1]};
          carry  <= fa_c;
          cnt    <= cnt - CNT_W'(1);
          // Last bit: the final sum bit is merged directly into the
          // output copy so the result appears on the same edge.
          if (cnt == CNT_W'(1)) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            sum   <= {fa_s, res_sr[WIDTH-1:1]};
            cout  <= fa_c;
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder
//   Self-checking bench for serial_adder at WIDTH=8: directed vector table,
//   hand-written corner sequences (start during RUN, reset during RUN,
//   back-to-back operations) and randomized operations checked against
//   plain integer addition.
module tb_serial_adder;

  localparam int unsigned W = 8;
`ifdef SERIAL_ADDER_CIN_EN
  localparam bit CIN_EN = 1'b1;
`else
  localparam bit CIN_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         start = 1'b0;
  logic         tb_cin = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [W-1:0] sum;
  logic         busy, done, cout;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
`ifdef SERIAL_ADDER_CIN_EN
    ,
    .cin   (tb_cin)
`endif
  );

  typedef struct {
    logic [W-1:0] va;
    logic [W-1:0] vb;
    logic         vc;
    logic [W-1:0] es;
    logic         ec;
  } vec_t;

  vec_t vecs[$];

  int unsigned  n_checks = 0;
  int unsigned  n_fail = 0;
  logic [W-1:0] last_sum = '0;
  logic         last_cout = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic launch(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vc);
    @(negedge clk);
    start  = 1'b1;
    a      = va;
    b      = vb;
    tb_cin = vc;
  endtask

  // Follows one operation from its accepting edge to the done cycle.
  // Operands are scrambled during the run; inject_at>0 pulses start
  // (with zero operands) after that RUN edge.
  task automatic run_check(input logic [W-1:0] es, input logic ec, input int unsigned inject_at);
    @(posedge clk); #1;
    chk("busy_after_accept", 32'(busy), 32'd1);
    chk("done_after_accept", 32'(done), 32'd0);
    @(negedge clk);
    start  = 1'b0;
    a      = W'($urandom);
    b      = W'($urandom);
    tb_cin = 1'($urandom);
    for (int unsigned k = 1; k <= W; k++) begin
      @(posedge clk); #1;
      if (k < W) begin
        chk("busy_in_run", 32'(busy), 32'd1);
        chk("done_in_run", 32'(done), 32'd0);
        chk("sum_held_in_run", 32'(sum), 32'(last_sum));
        chk("cout_held_in_run", 32'(cout), 32'(last_cout));
        @(negedge clk);
        start = (k == inject_at);
        if (k == inject_at) begin
          a = '0;
          b = '0;
        end else begin
          a = W'($urandom);
          b = W'($urandom);
        end
        tb_cin = 1'($urandom);
      end else begin
        chk("done_at_width", 32'(done), 32'd1);
        chk("busy_at_done", 32'(busy), 32'd0);
        chk("sum_result", 32'(sum), 32'(es));
        chk("cout_result", 32'(cout), 32'(ec));
        last_sum  = es;
        last_cout = ec;
      end
    end
  endtask

  task automatic idle_check();
    @(posedge clk); #1;
    chk("done_idle", 32'(done), 32'd0);
    chk("busy_idle", 32'(busy), 32'd0);
    chk("sum_idle", 32'(sum), 32'(last_sum));
    chk("cout_idle", 32'(cout), 32'(last_cout));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W:0]   e;
    logic [W-1:0] ra, rb;
    logic         rc;

    vecs.push_back('{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0});
    vecs.push_back('{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1});
    vecs.push_back('{8'hFF, 8'hFF, 1'b0, 8'hFE, 1'b1});
    vecs.push_back('{8'h12, 8'h34, 1'b0, 8'h46, 1'b0});
    vecs.push_back('{8'h80, 8'h80, 1'b0, 8'h00, 1'b1});
    vecs.push_back('{8'hAA, 8'h55, 1'b0, 8'hFF, 1'b0});
    vecs.push_back('{8'h00, 8'h00, 1'b0, 8'h00, 1'b0});
    vecs.push_back('{8'h7F, 8'h7F, 1'b0, 8'hFE, 1'b0});
`ifdef SERIAL_ADDER_CIN_EN
    vecs.push_back('{8'hFF, 8'h00, 1'b1, 8'h00, 1'b1});
    vecs.push_back('{8'h01, 8'h01, 1'b1, 8'h03, 1'b0});
    vecs.push_back('{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1});
`endif

    // Asynchronous reset, checked before any clock edge.
    #1 rst_n = 1'b0;
    #2;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idle_check();

    // Directed table; odd entries run back-to-back with the next one.
    foreach (vecs[i]) begin
      launch(vecs[i].va, vecs[i].vb, vecs[i].vc);
      run_check(vecs[i].es, vecs[i].ec, 0);
      if (i % 2 == 0) idle_check();
    end
    idle_check();

    // start pulsed during RUN is ignored: one result, no second operation.
    launch(8'h12, 8'h34, 1'b0);
    run_check(8'h46, 1'b0, 3);
    for (int i = 0; i < 10; i++) idle_check();

    // Reset in the middle of RUN clears outputs at once, no done follows.
    launch(8'h21, 8'h43, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrun_rst_busy", 32'(busy), 32'd0);
    chk("midrun_rst_done", 32'(done), 32'd0);
    chk("midrun_rst_sum", 32'(sum), 32'd0);
    chk("midrun_rst_cout", 32'(cout), 32'd0);
    last_sum  = '0;
    last_cout = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) idle_check();
    launch(8'h0F, 8'h01, 1'b0);
    run_check(8'h10, 1'b0, 0);

    // start held on the DONE cycle: next RUN begins with no gap.
    launch(8'h33, 8'h44, 1'b0);
    run_check(8'h77, 1'b0, 0);
    launch(8'hC8, 8'h64, 1'b0);
    run_check(8'h2C, 1'b1, 0);
    idle_check();

    // Randomized operations against integer addition.
    for (int i = 0; i < 40; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rc = 1'($urandom);
      e  = (W+1)'(ra) + (W+1)'(rb) + (W+1)'(CIN_EN ? rc : 1'b0);
      launch(ra, rb, rc);
      run_check(e[W-1:0], e[W], 0);
      if ($urandom_range(0, 1) == 1) idle_check();
    end
    idle_check();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, setting the operand and result width in bits (legal range 2..32).
REQ-002 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-003 Port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 Port start, input, 1 bit: request to begin an addition; sampled on the rising edge of clk.
REQ-005 Port a, input, WIDTH bits: first operand; sampled only on the edge that accepts start.
REQ-006 Port b, input, WIDTH bits: second operand; sampled only on the edge that accepts start.
REQ-007 Port busy, output, 1 bit: high while an addition is in progress.
REQ-008 Port done, output, 1 bit: one-cycle pulse marking that a new result is valid.
REQ-009 Port sum, output, WIDTH bits: registered result of the last completed addition.
REQ-010 Port cout, output, 1 bit: registered carry-out of the last completed addition.

Function
REQ-011 The block SHALL implement the FSM states IDLE, RUN and DONE.
REQ-012 The FSM SHALL leave IDLE or DONE for RUN on an edge with start=1; that edge SHALL load a and b into internal shift registers, clear the carry flip-flop and load the bit counter with WIDTH.
REQ-013 Each edge in RUN SHALL process the LSB of both shift registers plus the carry flip-flop, using a full adder built from two half adders and an OR gate.
REQ-014 On each RUN edge, the sum bit SHALL shift into the MSB of the internal result register, the carry bit SHALL update the carry flip-flop, both operand registers SHALL shift right, and the counter SHALL decrement.
REQ-015 The FSM SHALL move from RUN to DONE on the edge where the counter reaches 0, which is the WIDTH-th edge after the accepting edge.
REQ-016 That same edge SHALL copy the internal result register to sum and the carry flip-flop to cout.
REQ-017 done SHALL be high exactly during the DONE state (one cycle) and low otherwise.
REQ-018 busy SHALL equal (state==RUN).
REQ-019 Without start, DONE SHALL return to IDLE on the next edge.
REQ-020 With start=1 in DONE, the block SHALL enter RUN directly, so back-to-back additions run with no idle cycle.
REQ-021 start SHALL be ignored in RUN; the operation in progress SHALL be unaffected.
REQ-022 Changes on a or b after the accepting edge SHALL NOT affect the result.
REQ-023 sum and cout SHALL hold their value from completion until the next completion; they SHALL NOT change during RUN.
REQ-024 The result SHALL satisfy {cout,sum} = a + b (+ cin, see REQ-028), modulo 2^(WIDTH+1), i.e. unsigned wrap-around.

Reset
REQ-025 While rst_n=0, the block SHALL immediately, without waiting for a clock edge: set state to IDLE, and clear busy, done, sum, cout, the carry flip-flop, the counter and the shift registers to 0.
REQ-026 Reset asserted during RUN SHALL abort the operation with no done pulse; the first start after reset release SHALL behave as from IDLE.

Configuration
REQ-027 Macro SERIAL_ADDER_CIN_EN SHALL control the carry-in feature at compile time.
REQ-028 When SERIAL_ADDER_CIN_EN is defined, the block SHALL add a 1-bit input port cin, sampled on the accepting edge and loaded into the carry flip-flop instead of 0.
REQ-029 When SERIAL_ADDER_CIN_EN is undefined, port cin SHALL be absent and the initial carry SHALL be 0.

Verification (WIDTH=8)
REQ-030 Bench SHALL apply a=0x0F, b=0x01 with start for one cycle -> done at the 8th edge after the accepting edge, sum=0x10, cout=0, busy high for 8 cycles.
REQ-031 Bench SHALL apply a=0xFF, b=0x01 -> sum=0x00, cout=1; then a=0xFF, b=0xFF -> sum=0xFE, cout=1.
REQ-032 Bench SHALL pulse start with a=0x00, b=0x00 at cycle 3 of a RUN on 0x12+0x34 -> single done, sum=0x46, and no second operation.
REQ-033 Bench SHALL assert rst_n=0 at cycle 4 of RUN -> busy=0, done=0, sum=0x00 and cout=0 immediately; no done follows.
REQ-034 Bench SHALL hold start=1 with new operands on the DONE cycle -> next RUN starts with no gap and the second result is correct.
REQ-035 With SERIAL_ADDER_CIN_EN defined, bench SHALL apply a=0xFF, b=0x00, cin=1 -> sum=0x00, cout=1; and a=0x01, b=0x01, cin=1 -> sum=0x03, cout=0.
